// File: rtl/ram_param.sv
// rtl/ram_param.sv - parametrised WIDTH x 2**ADDR_W word RAM, write/read port A, read port B, clear sequencer
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   reset      - synchronous active-high reset; starts the clear sequence
//   clear      - clear request, accepted only while idle
//   load       - port A write enable (ignored while busy)
//   in         - port A write data
//   address    - port A address (write and read)
//   out        - port A read data
//   rd_address - port B read address
//   rd_out     - port B read data
//   busy       - high while the clear sequence is zeroing the array
module ram_param #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int REG_READ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [WIDTH-1:0]  rd_out,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_clr_ptr;
    logic [ADDR_W-1:0]  w_clr_ptr_next;

    // Array has no reset so it stays inferable as RAM; only the clear sequence zeroes it.
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [WIDTH-1:0]   w_mem_data;
    logic [WIDTH-1:0]   w_arr_a;
    logic [WIDTH-1:0]   w_arr_b;

    // Single write port shared by user writes and the clear sequencer.
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        w_mem_we       = 1'b0;
        w_mem_addr     = address;
        w_mem_data     = in;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    // A clear request wins over a same-edge load, which is dropped.
                    if (clear) begin
                        w_state_next   = ST_CLEAR;
                        w_clr_ptr_next = '0;
                    end else if (load) begin
                        w_mem_we = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    w_mem_we       = 1'b1;
                    w_mem_addr     = r_clr_ptr;
                    w_mem_data     = '0;
                    w_clr_ptr_next = r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LAST_ADDR) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign busy    = (r_state == ST_CLEAR);
    assign w_arr_a = r_mem[address];
    assign w_arr_b = r_mem[rd_address];

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [WIDTH-1:0] r_out;
            logic [WIDTH-1:0] r_rd_out;

            // Loading zero whenever the next state is CLEAR keeps both outputs at zero
            // for every busy cycle. The write-first bypass also covers the final clear
            // write, so the first idle cycle already shows the cleared word.
            always_ff @(posedge clk) begin
                if (reset || (w_state_next == ST_CLEAR)) begin
                    r_out    <= '0;
                    r_rd_out <= '0;
                end else begin
                    r_out    <= (w_mem_we && (w_mem_addr == address))    ? w_mem_data : w_arr_a;
                    r_rd_out <= (w_mem_we && (w_mem_addr == rd_address)) ? w_mem_data : w_arr_b;
                end
            end

            assign out    = r_out;
            assign rd_out = r_rd_out;
        end else begin : g_comb_read
            assign out    = busy ? '0 : w_arr_a;
            assign rd_out = busy ? '0 : w_arr_b;
        end
    endgenerate
endmodule

// File: tb/tb_ram_param.sv
// tb/tb_ram_param.sv - self-checking bench for ram_param (combinational, registered and wide configs)
module tb_ram_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the 16x8 combinational and registered instances
    logic        reset   = 1'b1;
    logic        clear   = 1'b0;
    logic        load    = 1'b0;
    logic [15:0] in_d    = '0;
    logic [2:0]  addr    = '0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] out0, rd0, out1, rd1;
    logic        busy0, busy1;

    // Wide 32x64 registered instance
    logic        w_reset   = 1'b1;
    logic        w_clear   = 1'b0;
    logic        w_load    = 1'b0;
    logic [31:0] w_in      = '0;
    logic [5:0]  w_addr    = '0;
    logic [5:0]  w_rd_addr = '0;
    logic [31:0] w_out, w_rd;
    logic        w_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    ram_param #(.WIDTH(16), .ADDR_W(3), .REG_READ(0)) u_comb (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .in(in_d),
        .address(addr), .out(out0), .rd_address(rd_addr), .rd_out(rd0), .busy(busy0)
    );

    ram_param #(.WIDTH(16), .ADDR_W(3), .REG_READ(1)) u_reg (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .in(in_d),
        .address(addr), .out(out1), .rd_address(rd_addr), .rd_out(rd1), .busy(busy1)
    );

    ram_param #(.WIDTH(32), .ADDR_W(6), .REG_READ(1)) u_wide (
        .clk(clk), .reset(w_reset), .clear(w_clear), .load(w_load), .in(w_in),
        .address(w_addr), .out(w_out), .rd_address(w_rd_addr), .rd_out(w_rd), .busy(w_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        step();
        reset = 1'b0;
        n_checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: busy0=%b busy1=%b required 1", busy0, busy1);
        end
        n_checks++;
        if (out1 !== 16'h0 || rd1 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_reg_out: out=%h rd_out=%h required 0000", out1, rd1);
        end
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            n_checks++;
            if (out0 !== 16'h0 || rd0 !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_busy_out: out=%h rd_out=%h required 0000", out0, rd0);
            end
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != 8 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_len: busy cycles=%0d busy1=%b required 8 and 0", cnt, busy1);
        end
        for (int a = 0; a < 8; a++) begin
            addr    = 3'(a);
            rd_addr = 3'(7 - a);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            step();
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({16'h0, out0} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_read_a%0d: out=%h required %h", a, out0, exp_v[15:0]);
            end
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({16'h0, rd0} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_read_b%0d: rd_out=%h required %h", 7 - a, rd0, exp_v[15:0]);
            end
        end
    endtask

    task automatic test_write_read_comb();
        addr    = 3'd5;
        rd_addr = 3'd5;
        in_d    = 16'hBEEF;
        load    = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hBEEF);
        exp_q.push_back(32'hBEEF);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, out0} !== exp_v) begin
            n_fail++;
            $display("FAIL comb_old_out: out=%h required %h", out0, exp_v[15:0]);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, rd0} !== exp_v) begin
            n_fail++;
            $display("FAIL comb_old_rd: rd_out=%h required %h", rd0, exp_v[15:0]);
        end
        step();
        load = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, out0} !== exp_v) begin
            n_fail++;
            $display("FAIL comb_new_out: out=%h required %h", out0, exp_v[15:0]);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, rd0} !== exp_v) begin
            n_fail++;
            $display("FAIL comb_new_rd: rd_out=%h required %h", rd0, exp_v[15:0]);
        end
    endtask

    task automatic test_reg_bypass();
        addr    = 3'd2;
        rd_addr = 3'd2;
        in_d    = 16'h1234;
        load    = 1'b1;
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'h1234);
        step();
        load = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, out1} !== exp_v) begin
            n_fail++;
            $display("FAIL reg_bypass_out: out=%h required %h", out1, exp_v[15:0]);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, rd1} !== exp_v) begin
            n_fail++;
            $display("FAIL reg_bypass_rd: rd_out=%h required %h", rd1, exp_v[15:0]);
        end
        addr    = 3'd3;
        rd_addr = 3'd0;
        in_d    = 16'h5678;
        load    = 1'b1;
        step();
        load = 1'b0;
        addr = 3'd2;
        step();
        addr    = 3'd3;
        rd_addr = 3'd3;
        exp_q.push_back(32'h5678);
        exp_q.push_back(32'h5678);
        #1;
        n_checks++;
        if (out1 !== 16'h1234) begin
            n_fail++;
            $display("FAIL reg_latency: out=%h required 1234 before the edge", out1);
        end
        step();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, out1} !== exp_v) begin
            n_fail++;
            $display("FAIL reg_read_out: out=%h required %h", out1, exp_v[15:0]);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, rd1} !== exp_v) begin
            n_fail++;
            $display("FAIL reg_read_rd: rd_out=%h required %h", rd1, exp_v[15:0]);
        end
    endtask

    task automatic test_load_ignored_busy();
        int cnt;
        int lat;
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            in_d = 16'h00A0 + 16'(i);
            load = 1'b1;
            step();
        end
        load = 1'b0;
        addr = 3'd6;
        exp_q.push_back(32'h00A6);
        step();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({16'h0, out0} !== exp_v || {16'h0, out1} !== exp_v) begin
            n_fail++;
            $display("FAIL fill_read: out0=%h out1=%h required %h", out0, out1, exp_v[15:0]);
        end
        // clear and load on the same edge: the load is dropped
        clear = 1'b1;
        load  = 1'b1;
        addr  = 3'd1;
        in_d  = 16'hFFFF;
        step();
        clear = 1'b0;
        lat = 1;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            load = (cnt < 3);
            n_checks++;
            if (out0 !== 16'h0 || out1 !== 16'h0) begin
                n_fail++;
                $display("FAIL clear_busy_out: out0=%h out1=%h required 0000", out0, out1);
            end
            cnt++;
            lat++;
            step();
        end
        load = 1'b0;
        n_checks++;
        if (cnt != 8 || lat != 9) begin
            n_fail++;
            $display("FAIL clear_busy_len: busy=%0d request_to_idle=%0d required 8 and 9", cnt, lat);
        end
        for (int a = 0; a < 8; a++) begin
            addr    = 3'(a);
            rd_addr = 3'(a);
            for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
            step();
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({16'h0, out0} !== exp_v) begin
                n_fail++;
                $display("FAIL clear_comb_out_a%0d: out=%h required %h", a, out0, exp_v[15:0]);
            end
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({16'h0, rd0} !== exp_v) begin
                n_fail++;
                $display("FAIL clear_comb_rd_a%0d: rd_out=%h required %h", a, rd0, exp_v[15:0]);
            end
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({16'h0, out1} !== exp_v) begin
                n_fail++;
                $display("FAIL clear_reg_out_a%0d: out=%h required %h", a, out1, exp_v[15:0]);
            end
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({16'h0, rd1} !== exp_v) begin
                n_fail++;
                $display("FAIL clear_reg_rd_a%0d: rd_out=%h required %h", a, rd1, exp_v[15:0]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        int lat;
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (4) step();
        // clear pointer is now 4
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != 8) begin
            n_fail++;
            $display("FAIL mid_reset_len: busy after reset=%0d required 8", cnt);
        end
        reset = 1'b1;
        lat = 0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0 && busy0 === 1'b1) cnt++;
            step();
            lat++;
        end
        reset = 1'b0;
        while (busy0 === 1'b1 && cnt < 40) begin
            cnt++;
            lat++;
            step();
        end
        n_checks++;
        if (cnt != 10 || lat != 11) begin
            n_fail++;
            $display("FAIL held_reset_len: busy=%0d assert_to_idle=%0d required 10 and 11", cnt, lat);
        end
    endtask

    task automatic test_wide();
        int cnt;
        step();
        w_reset = 1'b0;
        cnt = 0;
        while (w_busy === 1'b1 && cnt < 200) begin
            n_checks++;
            if (w_out !== 32'h0 || w_rd !== 32'h0) begin
                n_fail++;
                $display("FAIL wide_busy_out: out=%h rd_out=%h required 0", w_out, w_rd);
            end
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != 64) begin
            n_fail++;
            $display("FAIL wide_busy_len: busy cycles=%0d required 64", cnt);
        end
        w_addr = 6'd63;
        w_in   = 32'hDEADBEEF;
        w_load = 1'b1;
        step();
        w_load    = 1'b0;
        w_addr    = 6'd0;
        w_rd_addr = 6'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        step();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (w_out !== exp_v) begin
            n_fail++;
            $display("FAIL wide_addr0_out: out=%h required %h", w_out, exp_v);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (w_rd !== exp_v) begin
            n_fail++;
            $display("FAIL wide_addr0_rd: rd_out=%h required %h", w_rd, exp_v);
        end
        w_addr    = 6'd63;
        w_rd_addr = 6'd63;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        step();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (w_out !== exp_v) begin
            n_fail++;
            $display("FAIL wide_addr63_out: out=%h required %h", w_out, exp_v);
        end
        exp_v = exp_q.pop_front();
        n_checks++;
        if (w_rd !== exp_v) begin
            n_fail++;
            $display("FAIL wide_addr63_rd: rd_out=%h required %h", w_rd, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_write_read_comb();
        test_reg_bypass();
        test_load_ignored_busy();
        test_reset_mid_clear();
        test_wide();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
